// File: rtl/sat_extrinsic_sub_pkg.sv
// Shared types and helpers for the extrinsic extractor.
// The clamp here is also used by the combine-side adder.
package sat_extrinsic_sub_pkg;

  localparam int W_DEF       = 6;
  localparam int MAX_DEG_DEF = 8;

  typedef enum logic {
    COLLECT,
    EMIT
  } state_e;

  // Clamp a wide signed value into the w-bit two's complement range
  function automatic logic signed [31:0] sat_w(
    input logic signed [31:0] d,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

endpackage

// File: rtl/sat_extrinsic_sub_msg_buf.sv
// Per-group message store: one write port, one async read port.
// Out-of-range reads return zero.
module sat_extrinsic_sub_msg_buf
  import sat_extrinsic_sub_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = MAX_DEG_DEF,
  parameter int AW_IN = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW_IN-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [AW_IN-1:0] raddr,
  output logic [W-1:0]     rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < AW_IN'(DEPTH)))
      mem[waddr[AW-1:0]] <= wdata;
  end

  assign rdata = (raddr < AW_IN'(DEPTH)) ?
                 mem[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/sat_extrinsic_sub.sv
// Extrinsic extractor: buffers a message group, then streams
// sat(total - msg) per message in arrival order.
module sat_extrinsic_sub
  import sat_extrinsic_sub_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MAX_DEG = MAX_DEG_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] ch_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         deg_err
);

  localparam int ACC_W = W + $clog2(MAX_DEG + 1);
  localparam int CW    = $clog2(MAX_DEG + 1);
  localparam int DW    = ACC_W + 1;

  state_e                  state;
  logic [CW-1:0]           count;
  logic [CW-1:0]           rd_ptr;
  logic signed [ACC_W-1:0] total;

  logic                    accept;
  logic                    fire_last;
  logic                    ohs;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] tot_sel;
  logic [CW-1:0]           rd_addr;
  logic [W-1:0]            rd_data;
  logic [W-1:0]            elem;
  logic signed [DW-1:0]    diff;
  logic [W-1:0]            sat_out;
  logic                    nxt_last;

  assign in_ready  = (state == COLLECT);
  assign accept    = in_valid & in_ready;
  assign fire_last = accept &
                     (in_last | (count == CW'(MAX_DEG - 1)));
  assign ohs       = out_valid & out_ready;

  sat_extrinsic_sub_msg_buf #(
    .W     (W),
    .DEPTH (MAX_DEG),
    .AW_IN (CW)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (count),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Precompute the next output so out_data stays a pure register;
  // a single-message group bypasses the not-yet-written buffer.
  always_comb begin
    acc = (count == '0) ?
          ACC_W'($signed(ch_data)) + ACC_W'($signed(in_data)) :
          total + ACC_W'($signed(in_data));
    tot_sel  = (state == COLLECT) ? acc : total;
    rd_addr  = (state == COLLECT) ? '0 : rd_ptr + 1'b1;
    elem     = ((state == COLLECT) && (count == '0)) ?
               in_data : rd_data;
    diff     = DW'(tot_sel) - DW'($signed(elem));
    sat_out  = W'(sat_w(32'(diff), W));
    nxt_last = (state == COLLECT) ? (count == '0) :
               ((rd_ptr + 1'b1) == (count - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      count     <= '0;
      rd_ptr    <= '0;
      total     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      deg_err   <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (accept) begin
            count <= count + 1'b1;
            total <= acc;
            if (fire_last) begin
              state     <= EMIT;
              out_valid <= 1'b1;
              out_data  <= sat_out;
              out_last  <= nxt_last;
              if (!in_last) deg_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (ohs) begin
            if (out_last) begin
              state     <= COLLECT;
              count     <= '0;
              rd_ptr    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_ptr   <= rd_ptr + 1'b1;
              out_data <= sat_out;
              out_last <= nxt_last;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sat_extrinsic_sub.md
Name: sat_extrinsic_sub

Overview:
- Per-group extrinsic extractor; the inverse of the saturating multi-operand adder used in the node datapath.
- Collects one channel value plus a group of W-bit signed messages and holds them in an internal buffer, while accumulating a full-precision total.
- It then streams out, for each message in arrival order, the saturated value total minus that message.
- Sits between the message-combine stage and the message-return path of the node processor.

Parameters:
- W, 6, message and channel width, two's complement.
- MAX_DEG, 8, maximum messages per group; sets the buffer depth.
- ACC_W, W+$clog2(MAX_DEG+1), accumulator width; fixed and not overridable.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ch_data  in  W  channel value; sampled on the first accepted beat of a group.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  W  signed message.
- in_last  in  1  final message of the group.
- out_valid  out  1  extrinsic output valid.
- out_ready  in  1  consumer accepts the output.
- out_data  out  W  saturated extrinsic value.
- out_last  out  1  final extrinsic output of the group.
- deg_err  out  1  sticky flag: a group exceeded MAX_DEG messages.

Behaviour:
- Reset (synchronous, active-high) clears everything. State=COLLECT, in_ready=1, out_valid=0, out_data=0, out_last=0, deg_err=0, count=0, rd_ptr=0, total=0.
- Reset asserted mid-group or mid-emit discards the whole group. The next group starts clean.
- COLLECT state:
  - in_ready=1.
  - Accept when in_valid&in_ready. buf[count]<=in_data and count++.
  - On the first beat of a group: total<=sext(ch_data)+sext(in_data).
  - On later beats: total<=total+sext(in_data).
  - Accumulation is exact, with no intermediate saturation.
  - The accepted beat with in_last=1 moves the state to EMIT.
  - A beat accepted with count==MAX_DEG-1 and in_last=0 is treated as last. It also moves to EMIT and sets deg_err. deg_err is cleared only by rst.
- EMIT state:
  - in_ready=0.
  - out_valid asserts the cycle after the last beat is accepted.
  - Latency is 1 cycle from the last input handshake to the first out_valid.
  - diff = sext_{ACC_W+1}(total) - sext(buf[rd_ptr]).
  - out_data = sat_W(diff). If diff > 2^(W-1)-1, output 0 followed by W-1 ones. If diff < -2^(W-1), output 1 followed by W-1 zeros. Otherwise output diff[W-1:0].
  - out_last=1 when rd_ptr==count-1.
  - out_valid&~out_ready holds out_data and out_last stable; no beat is dropped or repeated.
  - On out_valid&out_ready, rd_ptr++. The out_last handshake returns the block to COLLECT with count=0, rd_ptr=0, out_valid=0 on the next cycle, and in_ready=1 that cycle.
- Output registers (out_data, out_last, out_valid) are registered; they do not depend combinationally on out_ready.
- A single-message group outputs sat_W(ch_data).
- in_valid is ignored while in_ready=0.

Decomposition:
- Shared package:
  - W and MAX_DEG defaults.
  - State enum {COLLECT, EMIT}.
  - A sat_W function (range check on the top bits, positive/negative clamp) shared with the combine-side adder so both clamp identically.
- One sub-module is natural: msg_buf, a MAX_DEG x W register file with one write port and one read port indexed by count/rd_ptr.
- The FSM, accumulator and subtract/saturate stay in the top level.

Test Plan (W=6, MAX_DEG=8):
- Basic: ch=10, msgs 5,-3,7(last) -> total 19; outputs 14,22,12; out_last only on 12; first out_valid 1 cycle after the last input handshake.
- Positive saturation: ch=31, msgs 31,31(last) -> total 93; outputs 31,31 (62 clamped). Negative saturation: ch=-32, msgs -32,-32(last) -> outputs -32,-32.
- Single message: ch=-7, msg 20(last) -> one output, -7, with out_last=1; next cycle in_ready=1.
- Backpressure: basic group with out_ready low for 3 cycles at each output -> out_data/out_last held stable; sequence 14,22,12 exactly once; in_ready=0 throughout EMIT.
- Degree overflow: ch=0, 8 msgs of 1 with in_last never set -> EMIT after the 8th beat; deg_err=1; 8 outputs of 7; the next group runs normally with deg_err still 1 until rst.
- Reset mid-emit: rst pulsed after the first output of the basic group -> next cycle out_valid=0, in_ready=1, deg_err=0; a new group ch=1, msgs 2,3(last) outputs 4,3.
